// File: rtl/ldst_pkg.sv
// Shared types and constants for the load/store sequencer.
package ldst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } ldst_state_t;

  localparam int LDST_BYTES_WIDE = 2;

endpackage

// File: rtl/ldst_unit.sv
// Load/store sequencer: turns one byte or two-byte request into byte-wide
// memory beats on a single-port memory and returns a one-cycle response.
//
// state | meaning
// IDLE  | ready for a request
// LO    | low byte beat at addr
// HI    | high byte beat at addr+1 (wraps)
// DONE  | response pulse
module ldst_unit
  import ldst_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           ReqValid,
  output logic                           ReqReady,
  input  logic                           ReqWrite,
  input  logic                           ReqWide,
  input  logic [A-1:0]                   ReqAddr,
  input  logic [LDST_BYTES_WIDE*W-1:0]   ReqWData,
  output logic                           RespValid,
  output logic [LDST_BYTES_WIDE*W-1:0]   RespRData,
  output logic                           Busy,
  output logic [A-1:0]                   MemAddr,
  output logic                           MemWriteEn,
  output logic [W-1:0]                   MemDataIn,
  input  logic [W-1:0]                   MemDataOut
);

  ldst_state_t                  state;
  logic [A-1:0]                 addr;
  logic [LDST_BYTES_WIDE*W-1:0] wdata;
  logic                         write;
  logic                         wide;
  logic [W-1:0]                 lo;
  logic [W-1:0]                 hi;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      addr  <= '0;
      wdata <= '0;
      write <= 1'b0;
      wide  <= 1'b0;
      lo    <= '0;
      hi    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            addr  <= ReqAddr;
            wdata <= ReqWData;
            write <= ReqWrite;
            wide  <= ReqWide;
            // Clearing here makes a byte load zero-extend for free.
            lo    <= '0;
            hi    <= '0;
            state <= LO;
          end
        end
        LO: begin
          if (!write) lo <= MemDataOut;
          state <= wide ? HI : DONE;
        end
        HI: begin
          if (!write) hi <= MemDataOut;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    MemAddr    = '0;
    MemDataIn  = '0;
    MemWriteEn = 1'b0;
    case (state)
      LO: begin
        MemAddr    = addr;
        MemDataIn  = wdata[W-1:0];
        MemWriteEn = write;
      end
      HI: begin
        MemAddr    = addr + A'(1);
        MemDataIn  = wdata[LDST_BYTES_WIDE*W-1:W];
        MemWriteEn = write;
      end
      default: ;
    endcase
  end

  assign ReqReady  = (state == IDLE);
  assign Busy      = (state != IDLE);
  assign RespValid = (state == DONE);
  assign RespRData = (state == DONE && !write) ? {hi, lo} : '0;

endmodule

// File: tb/tb_ldst_unit.sv
// Directed and randomized check of ldst_unit against a transaction-level
// memory model.
module tb_ldst_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid, ReqReady, ReqWrite, ReqWide;
  logic [7:0]  ReqAddr;
  logic [15:0] ReqWData;
  logic        RespValid, Busy, MemWriteEn;
  logic [15:0] RespRData;
  logic [7:0]  MemAddr, MemDataIn, MemDataOut;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];

  int nvec = 0;
  int nbad = 0;

  always #5 Clk = ~Clk;

  ldst_unit #(.W(8), .A(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqWide(ReqWide), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespRData(RespRData), .Busy(Busy),
    .MemAddr(MemAddr), .MemWriteEn(MemWriteEn), .MemDataIn(MemDataIn),
    .MemDataOut(MemDataOut)
  );

  // Data memory: combinational read, clocked write.
  assign MemDataOut = mem[MemAddr];
  always @(posedge Clk) if (MemWriteEn) mem[MemAddr] <= MemDataIn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_load(input logic wide, input logic [7:0] a);
    logic [7:0] a1;
    a1 = 8'((int'(a) + 1) % 256);
    return wide ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  task automatic ref_store(input logic wide, input logic [7:0] a, input logic [15:0] d);
    ref_mem[a] = d[7:0];
    if (wide) ref_mem[8'((int'(a) + 1) % 256)] = d[15:8];
  endtask

  // One complete request; with hold=1 ReqValid stays high and the request
  // fields churn while the unit is busy.
  task automatic txn(input logic wr, input logic wd, input logic [7:0] a,
                     input logic [15:0] d, input logic hold);
    int lat;
    int waited;
    logic [15:0] exp_data;
    lat = wd ? 3 : 2;
    @(negedge Clk);
    waited = 0;
    while (!ReqReady && waited < 10) begin
      @(negedge Clk);
      waited++;
    end
    chk("ready_before_req", 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWrite = wr; ReqWide = wd; ReqAddr = a; ReqWData = d;
    exp_data = wr ? 16'h0000 : ref_load(wd, a);
    if (wr) ref_store(wd, a, d);
    @(posedge Clk);
    for (int k = 1; k <= lat; k++) begin
      @(negedge Clk);
      if (hold) begin
        ReqAddr  = 8'($urandom);
        ReqWData = 16'($urandom);
      end else begin
        ReqValid = 1'b0;
      end
      chk("ready_busy", 32'(ReqReady), 32'd0);
      chk("busy", 32'(Busy), 32'd1);
      chk("resp_valid", 32'(RespValid), 32'(k == lat));
      if (k == 1) begin
        chk("lo_addr", 32'(MemAddr), 32'(a));
        chk("lo_we", 32'(MemWriteEn), 32'(wr));
        chk("lo_din", 32'(MemDataIn), 32'(d[7:0]));
      end else if (k == 2 && wd) begin
        chk("hi_addr", 32'(MemAddr), 32'((int'(a) + 1) % 256));
        chk("hi_we", 32'(MemWriteEn), 32'(wr));
        chk("hi_din", 32'(MemDataIn), 32'(d[15:8]));
      end else begin
        chk("done_we", 32'(MemWriteEn), 32'd0);
        chk("done_addr", 32'(MemAddr), 32'd0);
        chk("resp_data", 32'(RespRData), 32'(exp_data));
      end
    end
  endtask

  initial begin
    logic [7:0]  a;
    logic [15:0] d;
    logic [7:0]  old41;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    ReqValid = 0; ReqWrite = 0; ReqWide = 0; ReqAddr = 0; ReqWData = 0;
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rst_ready", 32'(ReqReady), 32'd1);
    chk("rst_resp_valid", 32'(RespValid), 32'd0);
    chk("rst_we", 32'(MemWriteEn), 32'd0);
    chk("rst_rdata", 32'(RespRData), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_maddr", 32'(MemAddr), 32'd0);

    txn(1, 0, 8'h10, 16'h00A5, 0);
    chk("mem10", 32'(mem[8'h10]), 32'h A5);
    txn(0, 0, 8'h10, 16'h0000, 0);

    txn(1, 1, 8'h20, 16'hBEEF, 0);
    chk("mem20", 32'(mem[8'h20]), 32'hEF);
    chk("mem21", 32'(mem[8'h21]), 32'hBE);
    txn(0, 1, 8'h20, 16'h0000, 0);

    txn(1, 1, 8'hFF, 16'h1234, 0);
    chk("memff", 32'(mem[8'hFF]), 32'h34);
    chk("mem00", 32'(mem[8'h00]), 32'h12);
    txn(0, 1, 8'hFF, 16'h0000, 0);

    // Held request: second one accepted only after returning to IDLE.
    txn(0, 1, 8'h20, 16'h0000, 1);
    txn(0, 0, 8'h21, 16'h0000, 0);

    // Reset during HI of a wide store.
    old41 = mem[8'h41];
    @(negedge Clk);
    ReqValid = 1; ReqWrite = 1; ReqWide = 1; ReqAddr = 8'h40; ReqWData = 16'hCAFE;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 0;
    @(negedge Clk);
    chk("abort_in_hi", 32'(MemAddr), 32'h41);
    Reset = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_resp", 32'(RespValid), 32'd0);
    chk("abort_we", 32'(MemWriteEn), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    ref_mem[8'h40] = 8'hFE;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      chk("abort_no_resp", 32'(RespValid), 32'd0);
    end
    chk("mem40", 32'(mem[8'h40]), 32'hFE);
    chk("mem41", 32'(mem[8'h41]), 32'(old41));

    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      d = 16'($urandom);
      txn(1'($urandom), 1'($urandom), a, d, 1'($urandom));
    end
    @(negedge Clk);
    ReqValid = 0;
    repeat (4) @(negedge Clk);
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) chk("mem_final", 32'(mem[i]), 32'(ref_mem[i]));
    end
    chk("final_idle", 32'(Busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/ldst_unit.md
Name: ldst_unit

Overview:
- Load/store sequencer between the core's memory-access request and the single-port, byte-wide data memory.
- The memory has a combinational read and a clocked write through one address pointer.
- Accepts one byte or two-byte (little-endian) load/store per request and issues one memory beat per cycle.
- Returns a one-cycle response pulse carrying load data, or acknowledging a store.

Parameters:
- W, 8, memory data width (bits per entry); response/request data is 2*W.
- A, 8, memory address width; memory depth 2**A.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  unit can accept a request this cycle.
- ReqWrite  input  1  1 = store, 0 = load.
- ReqWide  input  1  1 = two-byte access, 0 = single byte.
- ReqAddr  input  A  byte address of the low byte.
- ReqWData  input  2*W  store data; [W-1:0] = low byte, [2W-1:W] = high byte.
- RespValid  output  1  one-cycle completion pulse.
- RespRData  output  2*W  load result, valid while RespValid=1.
- Busy  output  1  access in progress (state != IDLE).
- MemAddr  output  A  to memory address pointer.
- MemWriteEn  output  1  to memory write enable.
- MemDataIn  output  W  to memory write data.
- MemDataOut  input  W  from memory combinational read data.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State is IDLE.
  - Latched addr/wdata/write/wide and captured lo/hi bytes are 0.
  - RespValid=0, RespRData=0, MemWriteEn=0, MemAddr=0, MemDataIn=0, ReqReady=1 once Reset deasserts.
- FSM states are IDLE, LO, HI, DONE.
  - IDLE: ReqReady=1.
    - Handshake ReqValid&&ReqReady at posedge latches ReqAddr, ReqWData, ReqWrite, ReqWide; next state LO.
    - ReqValid without acceptance has no effect.
  - LO: MemAddr=addr. MemDataIn=wdata[W-1:0]. MemWriteEn=write.
    - On load, MemDataOut is captured into lo at the posedge.
    - On store, the memory writes at the same posedge.
    - Next state is HI if wide, else DONE.
  - HI: MemAddr=(addr+1) mod 2**A; address 255 wraps to 0. MemDataIn=wdata[2W-1:W]. MemWriteEn=write.
    - On load, MemDataOut is captured into hi.
    - Next state DONE.
  - DONE: RespValid=1 for exactly this cycle.
    - Load: RespRData={hi,lo}; for a byte load hi=0 (zero-extended).
    - Store: RespRData=0.
    - Next state IDLE.
- ReqReady=0 in LO/HI/DONE; requests are not accepted until back in IDLE, so there is no back-to-back overlap.
- Throughput: byte access takes 3 cycles per request (accept, LO, DONE); wide access takes 4.
- Latency from the accept edge: RespValid is high 2 cycles later (byte) or 3 cycles later (wide).
- Outside LO/HI: MemWriteEn=0, MemAddr=0, MemDataIn=0.
  - MemWriteEn is decoded from registered state only; it does not depend on any Req* input.
- RespRData, RespValid and all Mem* outputs are driven from registers/state decode. There is no combinational path from Req* to Mem*.
- Reset mid-operation returns to IDLE immediately with no response.
  - A wide store interrupted after LO leaves the low byte written and the high byte unwritten. This is accepted behaviour.
- Request inputs change while Busy: ignored; the latched values are used.
- The memory's own Reset input is unused by this unit; the top level ties it inactive.

Decomposition:
- Package ldst_pkg holds:
  - typedef enum logic [1:0] {IDLE, LO, HI, DONE} ldst_state_t.
  - Constant LDST_BYTES_WIDE = 2.
- Single module, no sub-module; FSM and datapath regs together are under 200 lines.
- The bench instantiates ldst_unit with a DataMem of W=8, A=8.

Test Plan:
- Reset low mid-IDLE, then release -> ReqReady=1, RespValid=0, MemWriteEn=0, RespRData=0.
- Byte store addr=0x10 data=0x00A5, then byte load 0x10:
  - store -> MemWriteEn high exactly one cycle with MemAddr=0x10, MemDataIn=0xA5; RespValid 2 cycles after accept.
  - load -> RespRData=0x00A5 with RespValid 2 cycles after accept.
- Wide store addr=0x20 data=0xBEEF, then wide load 0x20:
  - store -> mem[0x20]=0xEF, mem[0x21]=0xBE.
  - load -> RespRData=0xBEEF with RespValid 3 cycles after accept.
- Wrap: wide store addr=0xFF data=0x1234 -> mem[0xFF]=0x34, mem[0x00]=0x12; wide load 0xFF -> 0x1234.
- Hold ReqValid=1 with changing ReqAddr during a wide load -> only one access; ReqReady=0 for 3 cycles; second request accepted only in IDLE.
- Assert Reset in HI of a wide store 0x40 data=0xCAFE:
  - No RespValid; state IDLE; mem[0x40]=0xFE; mem[0x41] unchanged.
